// File: rtl/eop_filter_detect.sv
// USB receive end-of-packet detector: counts strobed SE0 samples and accepts an EOP only
// when a long-enough SE0 run is closed by a J; malformed endings and SE0 overruns pulse eop_err.
module eop_filter_detect #(
   parameter int SE0_MIN = 2,
   parameter int SE0_MAX = 4
) (
   input  logic clk,
   input  logic n_rst,
   input  logic d_plus_sync,
   input  logic d_minus_sync,
   input  logic shift_enable,
   output logic se0,
   output logic eop,
   output logic eop_err
);

   localparam int CW = $clog2(SE0_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_STUCK = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [CW-1:0]   w_cnt_inc;
   logic            r_se0;
   logic            r_eop;
   logic            r_eop_err;
   logic            w_se0_nxt;
   logic            w_eop_nxt;
   logic            w_err_nxt;
   logic            w_smp_se0;
   logic            w_smp_j;
   logic            w_run_full;

   assign w_smp_se0  = !d_plus_sync && !d_minus_sync;
   assign w_smp_j    = d_plus_sync && !d_minus_sync;
   assign w_cnt_inc  = r_cnt + CW'(1);
   assign w_run_full = (w_cnt_inc == CW'(SE0_MAX));

   // State, run counter and all outputs are registered here.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_se0     <= 1'b0;
         r_eop     <= 1'b0;
         r_eop_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_se0     <= w_se0_nxt;
         r_eop     <= w_eop_nxt;
         r_eop_err <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (shift_enable) begin
         case (r_state)
            S_IDLE: begin
               if (w_smp_se0) begin
                  w_state_nxt = S_RUN;
                  w_cnt_nxt   = CW'(1);
               end else begin
                  w_cnt_nxt   = '0;
               end
            end
            S_RUN: begin
               if (w_smp_se0) begin
                  // Leaving for STUCK at SE0_MAX keeps the counter from ever passing it.
                  w_cnt_nxt = w_cnt_inc;
                  if (w_run_full) w_state_nxt = S_STUCK;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            S_STUCK: begin
               if (!w_smp_se0) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      w_eop_nxt = 1'b0;
      w_err_nxt = 1'b0;
      w_se0_nxt = shift_enable ? w_smp_se0 : r_se0;
      if (shift_enable && (r_state == S_RUN)) begin
         if (w_smp_se0) begin
            w_err_nxt = w_run_full;
         end else if (w_smp_j) begin
            if (r_cnt >= CW'(SE0_MIN)) w_eop_nxt = 1'b1;
            else                       w_err_nxt = 1'b1;
         end else begin
            w_err_nxt = 1'b1;
         end
      end
   end

   assign se0     = r_se0;
   assign eop     = r_eop;
   assign eop_err = r_eop_err;

endmodule

// File: tb/tb_eop_filter_detect.sv
// Directed bench for eop_filter_detect (SE0_MIN=2, SE0_MAX=4): table of strobed line states
// with expected {se0,eop,eop_err}, plus hand sequences for reset, strobe gating and back-to-back strobes.
module tb_eop_filter_detect;

   localparam logic [1:0] L_SE0 = 2'b00;
   localparam logic [1:0] L_J   = 2'b10;
   localparam logic [1:0] L_K   = 2'b01;
   localparam logic [1:0] L_SE1 = 2'b11;

   typedef struct {
      logic [1:0] line;
      logic [2:0] exp;
   } vec_t;

   logic clk;
   logic n_rst;
   logic d_plus_sync;
   logic d_minus_sync;
   logic shift_enable;
   logic se0;
   logic eop;
   logic eop_err;

   int n_tests;
   int n_fail;
   vec_t tbl[$];

   eop_filter_detect #(.SE0_MIN(2), .SE0_MAX(4)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .d_plus_sync  (d_plus_sync),
      .d_minus_sync (d_minus_sync),
      .shift_enable (shift_enable),
      .se0          (se0),
      .eop          (eop),
      .eop_err      (eop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [2:0] exp);
      n_tests++;
      if ({se0, eop, eop_err} !== exp) begin
         n_fail++;
         $display("FAIL %s: se0/eop/err got %b expected %b", name, {se0, eop, eop_err}, exp);
      end
   endtask

   task automatic add(input logic [1:0] l, input logic [2:0] e);
      vec_t v;
      v.line = l;
      v.exp  = e;
      tbl.push_back(v);
   endtask

   // Drive a line state with one strobe; returns at the following negedge, when the
   // registered result of that sample is visible.
   task automatic strobe(input logic [1:0] l);
      @(negedge clk);
      {d_plus_sync, d_minus_sync} = l;
      shift_enable = 1'b1;
      @(negedge clk);
      shift_enable = 1'b0;
   endtask

   task automatic gap_random(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         {d_plus_sync, d_minus_sync} = 2'($urandom);
      end
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      n_rst        = 1'b0;
      d_plus_sync  = 1'b1;
      d_minus_sync = 1'b0;
      shift_enable = 1'b0;

      // valid EOP
      add(L_J,   3'b000); add(L_SE0, 3'b100); add(L_SE0, 3'b100); add(L_J, 3'b010);
      // SE0 glitch
      add(L_J,   3'b000); add(L_SE0, 3'b100); add(L_J,   3'b001);
      // bad terminators
      add(L_SE0, 3'b100); add(L_SE0, 3'b100); add(L_K,   3'b001);
      add(L_SE0, 3'b100); add(L_SE1, 3'b001);
      // overrun: error on 4th SE0 only, silent exit from STUCK
      add(L_SE0, 3'b100); add(L_SE0, 3'b100); add(L_SE0, 3'b100); add(L_SE0, 3'b101);
      add(L_SE0, 3'b100); add(L_SE0, 3'b100); add(L_J,   3'b000);
      // recovery after stuck
      add(L_SE0, 3'b100); add(L_SE0, 3'b100); add(L_J,   3'b010);
      // three SE0 (above minimum, below max) then J
      add(L_SE0, 3'b100); add(L_SE0, 3'b100); add(L_SE0, 3'b100); add(L_J, 3'b010);

      #3;
      chk("reset_async", 3'b000);
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      chk("reset_release", 3'b000);

      foreach (tbl[i]) begin
         strobe(tbl[i].line);
         chk($sformatf("vec%0d", i), tbl[i].exp);
         gap_random(1);
         chk($sformatf("vec%0d_hold", i), {tbl[i].exp[2], 2'b00});
         gap_random(5);
      end

      // reset in the middle of an SE0 run
      strobe(L_SE0);
      strobe(L_SE0);
      chk("pre_reset_se0", 3'b100);
      #2 n_rst = 1'b0;
      #1 chk("reset_mid_run", 3'b000);
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      strobe(L_J);
      chk("after_reset_J", 3'b000);
      strobe(L_SE0);
      strobe(L_SE0);
      strobe(L_J);
      chk("after_reset_eop", 3'b010);

      // gating: line wiggles without strobe must not disturb anything
      strobe(L_SE0);
      chk("gate_start", 3'b100);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         {d_plus_sync, d_minus_sync} = 2'(i);
      end
      @(negedge clk);
      chk("gate_hold", 3'b100);
      strobe(L_K);
      chk("gate_exit_err", 3'b001);

      // back-to-back strobes: SE0, SE0, J on consecutive cycles
      @(negedge clk);
      {d_plus_sync, d_minus_sync} = L_SE0;
      shift_enable = 1'b1;
      @(negedge clk);
      chk("b2b_1", 3'b100);
      @(negedge clk);
      chk("b2b_2", 3'b100);
      {d_plus_sync, d_minus_sync} = L_J;
      @(negedge clk);
      shift_enable = 1'b0;
      chk("b2b_eop", 3'b010);
      @(negedge clk);
      chk("b2b_after", 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/eop_filter_detect.md
# eop_filter_detect

Sequential, parametrised end-of-packet detector for the USB receiver. It replaces the purely combinational SE0 decode with a bit-rate-sampled state machine. An EOP is accepted only when SE0 is held for a programmable number of bit samples and then followed by a J state. Malformed endings are flagged as errors. It sits between the D+/D− synchronisers and the receiver control FSM, and uses the same `shift_enable` bit strobe as the edge detector and shift register.

## Interface
- `SE0_MIN`, default 2: minimum consecutive SE0 bit samples required before J for a valid EOP (≥1).
- `SE0_MAX`, default 4: SE0 run length, in samples, at which the line is declared stuck/reset (must be > `SE0_MIN`).
- `clk` input, 1: system clock, all state on rising edge.
- `n_rst` input, 1: asynchronous active-low reset.
- `d_plus_sync` input, 1: synchronised D+ line.
- `d_minus_sync` input, 1: synchronised D− line.
- `shift_enable` input, 1: one-cycle bit-sample strobe; the line is evaluated only when high.
- `se0` output, 1: registered level, 1 while the last sampled bit was SE0.
- `eop` output, 1: one-cycle pulse, valid EOP detected.
- `eop_err` output, 1: one-cycle pulse, malformed EOP or SE0 overrun.

## Operation
- Sample decode (only when `shift_enable`=1):
  - SE0 = D+ 0, D− 0.
  - J = D+ 1, D− 0.
  - K = D+ 0, D− 1.
  - SE1 = D+ 1, D− 1.
- Run-length counter `cnt`, width $clog2(SE0_MAX+1). Unsigned, saturates at `SE0_MAX`, never wraps.
- States:
  - IDLE. On sample SE0: `cnt`←1, go to SE0_RUN. Any other sample: stay in IDLE.
  - SE0_RUN.
    - Sample SE0: `cnt`←`cnt`+1. If the new count equals `SE0_MAX`, pulse `eop_err` and go to STUCK.
    - Sample J with `cnt`≥`SE0_MIN`: pulse `eop`, go to IDLE.
    - Sample J with `cnt`<`SE0_MIN`: pulse `eop_err` (SE0 glitch), go to IDLE.
    - Sample K or SE1: pulse `eop_err`, go to IDLE.
  - STUCK. Stay while samples are SE0, with no further pulses. First non-SE0 sample: go to IDLE, no pulse.
- `se0` updates on every sampled bit to (sample==SE0). It holds its value between strobes.
- Cycles with `shift_enable`=0: state, `cnt` and `se0` hold; `eop` and `eop_err` are 0.
- `eop` and `eop_err` are never high in the same cycle.
- `cnt` is don't-care in IDLE and STUCK; it is cleared to 0 on every IDLE entry.

## Timing
- Reset (async, `n_rst`=0): state IDLE, `cnt`=0, `se0`=0, `eop`=0, `eop_err`=0. Applies immediately, independent of `clk`.
- Reset mid-run: any SE0 count in progress is discarded, with no pulse on release.
- All outputs are registered; nothing is combinational from the inputs to the outputs.
- Latency: `eop` or `eop_err` is high for exactly the one `clk` cycle following the edge at which the deciding sample (`shift_enable`=1) was taken.
- `se0` reflects the sample taken at the previous edge with `shift_enable`=1.
- Back-to-back strobes, i.e. `shift_enable` high on consecutive cycles, must be handled; each strobe counts as one bit.
- Line changes between strobes are ignored; only the strobed values matter.

## Test plan
All scenarios use `SE0_MIN`=2, `SE0_MAX`=4, with `shift_enable` pulsed every 8 clocks unless noted.
- Reset: hold `n_rst`=0 mid-SE0 run, then release. Required: all outputs 0 immediately; no `eop` afterwards until a new 2×SE0 + J.
- Valid EOP: samples J, SE0, SE0, J. Required: `eop`=1 for one clock after the 4th strobe edge; `eop_err` stays 0; `se0` reads 1 after strobes 2–3 and 0 after strobe 4.
- Glitch: samples J, SE0, J. Required: `eop_err` one-clock pulse after strobe 3; `eop` stays 0.
- Bad terminator: samples SE0, SE0, K, then SE0, SE1. Required: `eop_err` pulses after strobe 3 and after strobe 5; `eop` never asserts.
- Overrun/stuck: six SE0 samples, then J. Required: exactly one `eop_err` pulse, after strobe 4; no pulse on strobes 5–6 or on the J; the next SE0, SE0, J sequence gives a normal `eop`.
- Strobe gating and back-to-back: toggle D+/D− freely with `shift_enable`=0 and verify no output change. Then apply SE0, SE0, J on three consecutive-cycle strobes and require `eop` one clock after the third.
